// File: rtl/prescaled_counter_pkg.sv
// ============================================================================
// Module  : prescaled_counter_pkg
// Brief   : Shared constants and elaboration-time helpers for prescaled_counter
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package prescaled_counter_pkg;

    localparam int c_WIDTH_MIN = 1;
    localparam int c_WIDTH_MAX = 32;

    // A zero or negative tick rate yields DIV=0 so the range check can flag it.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        if (tick_hz <= 0) begin
            return 0;
        end
        return clk_hz / tick_hz;
    endfunction

    function automatic int pre_width(input int div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage : prescaled_counter_pkg

`default_nettype wire

// File: rtl/prescaled_counter_tick_gen.sv
// ============================================================================
// Module  : tick_gen
// Brief   : Enable-gated prescaler producing one registered tick per DIV clocks
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tick_gen
    import prescaled_counter_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int                 c_PRE_W = pre_width(DIV);
    localparam logic [c_PRE_W-1:0] c_LAST  = c_PRE_W'(DIV - 1);

    generate
        if (DIV < 1) begin : g_div_check
            $error("tick_gen: DIV must be at least 1");
        end
    endgenerate

    logic [c_PRE_W-1:0] r_pre;
    logic               r_tick;
    logic               w_last;

    assign w_last = (r_pre == c_LAST);

    // Wrapping on the terminal value (not after it) keeps the period at DIV.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else if (en) begin
            r_tick <= w_last;
            r_pre  <= w_last ? '0 : r_pre + c_PRE_W'(1);
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule : tick_gen

`default_nettype wire

// File: rtl/prescaled_counter.sv
// ============================================================================
// Module  : prescaled_counter
// Brief   : Up/down counter stepped by a CLK_HZ/TICK_HZ prescaler, with load.
//           Define PRESCALED_COUNTER_SAT_EN to saturate instead of wrapping.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module prescaled_counter
    import prescaled_counter_pkg::*;
#(
    parameter int CLK_HZ  = 12000000,
    parameter int TICK_HZ = 1,
    parameter int WIDTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             term
);

    localparam int c_DIV = calc_div(CLK_HZ, TICK_HZ);

    generate
        if (c_DIV < 1) begin : g_div_check
            $error("prescaled_counter: CLK_HZ/TICK_HZ must be at least 1");
        end
        if ((WIDTH < c_WIDTH_MIN) || (WIDTH > c_WIDTH_MAX)) begin : g_width_check
            $error("prescaled_counter: WIDTH must be within 1..32");
        end
    endgenerate

    logic             w_tick;
    logic             w_step_en;
    logic             w_at_max;
    logic             w_at_min;
    logic             w_boundary;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] r_count;
    logic             r_term;

    tick_gen #(
        .DIV (c_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .tick (w_tick)
    );

    assign w_step_en  = en & w_tick;
    assign w_at_max   = (r_count == '1);
    assign w_at_min   = (r_count == '0);
    assign w_boundary = up ? w_at_max : w_at_min;

    always_comb begin
        w_next = r_count;
`ifdef PRESCALED_COUNTER_SAT_EN
        if (!w_boundary) begin
            w_next = up ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
        end
`else
        w_next = up ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
`endif
    end

    // Load outranks a step that is due in the same cycle; the step is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_term  <= 1'b0;
        end else if (load) begin
            r_count <= load_val;
            r_term  <= 1'b0;
        end else if (w_step_en) begin
            r_count <= w_next;
            r_term  <= w_boundary;
        end else begin
            r_term  <= 1'b0;
        end
    end

    assign count = r_count;
    assign tick  = w_tick;
    assign term  = r_term;

endmodule : prescaled_counter

`default_nettype wire
